// File: rtl/matrix_scan.sv
// matrix_scan: renders the ball and both paddles onto a row-multiplexed
// 16x16 LED matrix.
//
// Each row is first held dark for BLANK cycles to suppress ghosting. It is
// then driven for DWELL cycles. One frame is 16*(BLANK+DWELL) cycles long.
// All positions are copied into shadow registers on the frame_start cycle,
// so one frame always shows one consistent snapshot.
//
// Ports:
//   clk          game clock
//   reset        synchronous, active-low reset
//   ball_x/y     ball column/row, 0..15
//   lpad/rpad    top row of the left (column 0) / right (column 15) paddle
//   row          index of the currently selected row
//   row_en       high while the selected row is driven
//   cols         column drive; bit i lights column i
//   frame_start  one-cycle pulse on the first cycle of each frame
//   dbg_state    current FSM state (0 = BLANK, 1 = DRIVE)
module matrix_scan #(
  parameter int DWELL      = 8,
  parameter int BLANK      = 1,
  parameter int PADDLE_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ball_x,
  input  logic [3:0]  ball_y,
  input  logic [3:0]  lpad,
  input  logic [3:0]  rpad,
  output logic [3:0]  row,
  output logic        row_en,
  output logic [15:0] cols,
  output logic        frame_start,
  output logic        dbg_state
);

  localparam int MAXP = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [PW-1:0] phase_q, phase_d;
  // run_q is clear for the first cycle after reset. The scan is held at
  // row 0 / phase 0 until run_q sets. This keeps frame_start low while
  // reset is held, and makes it pulse on the first cycle after release.
  logic          run_q;
  logic [3:0]    sh_bx_q, sh_by_q, sh_lp_q, sh_rp_q;
  logic          fs_w;
  logic [15:0]   pattern_w;

  assign fs_w = run_q && (state_q == S_BLANK) && (row_q == 4'd0) &&
                (phase_q == '0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    phase_d = phase_q;
    if (run_q) begin
      phase_d = phase_q + PW'(1);
      case (state_q)
        S_BLANK: begin
          if (phase_q == PW'(BLANK - 1)) begin
            state_d = S_DRIVE;
            phase_d = '0;
          end
        end
        S_DRIVE: begin
          if (phase_q == PW'(DWELL - 1)) begin
            state_d = S_BLANK;
            phase_d = '0;
            row_d   = row_q + 4'd1;
          end
        end
        default: begin
          state_d = S_BLANK;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_BLANK;
      row_q   <= 4'd0;
      phase_q <= '0;
      run_q   <= 1'b0;
      sh_bx_q <= 4'd0;
      sh_by_q <= 4'd0;
      sh_lp_q <= 4'd0;
      sh_rp_q <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      run_q   <= 1'b1;
      if (fs_w) begin
        sh_bx_q <= ball_x;
        sh_by_q <= ball_y;
        sh_lp_q <= lpad;
        sh_rp_q <= rpad;
      end
    end
  end

  // Row pattern, decoded from registered state only.
  // The paddle span is compared in 5 bits. A paddle near the bottom is
  // clipped at row 15 and does not wrap to row 0.
  always_comb begin
    pattern_w = '0;
    if (row_q == sh_by_q)
      pattern_w[sh_bx_q] = 1'b1;
    if (({1'b0, row_q} >= {1'b0, sh_lp_q}) &&
        ({1'b0, row_q} <= ({1'b0, sh_lp_q} + 5'(PADDLE_LEN - 1))))
      pattern_w[0] = 1'b1;
    if (({1'b0, row_q} >= {1'b0, sh_rp_q}) &&
        ({1'b0, row_q} <= ({1'b0, sh_rp_q} + 5'(PADDLE_LEN - 1))))
      pattern_w[15] = 1'b1;
  end

  assign row         = row_q;
  assign row_en      = (state_q == S_DRIVE);
  assign cols        = (state_q == S_DRIVE) ? pattern_w : 16'h0000;
  assign frame_start = fs_w;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Testbench for matrix_scan with the default parameters
// (DWELL=8, BLANK=1, so a row slot is 9 cycles and a frame is 144 cycles).
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, away from the active rising edge.
module tb_matrix_scan;

  localparam int SLOT  = 9;
  localparam int FRAME = 144;

  logic        clk;
  logic        reset;
  logic [3:0]  ball_x, ball_y, lpad, rpad;
  logic [3:0]  row;
  logic        row_en;
  logic [15:0] cols;
  logic        frame_start;
  logic        dbg_state;

  int checks;
  int failures;

  matrix_scan dut (
    .clk         (clk),
    .reset       (reset),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .lpad        (lpad),
    .rpad        (rpad),
    .row         (row),
    .row_en      (row_en),
    .cols        (cols),
    .frame_start (frame_start),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_inputs(input logic [3:0] bx, input logic [3:0] by,
                            input logic [3:0] lp, input logic [3:0] rp);
    ball_x = bx;
    ball_y = by;
    lpad   = lp;
    rpad   = rp;
  endtask

  // Applies reset for one edge and then releases it.
  // On return the bench sits on the frame_start cycle (t=0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Checks one full frame, starting at t=0, against hand-computed row
  // patterns. If chg_t >= 0, ball_y is changed to chg_by at that cycle.
  // On return the bench sits on t=0 of the next frame.
  task automatic run_frame(input logic [15:0] pat [16], input int chg_t,
                           input logic [3:0] chg_by, input string name);
    for (int t = 0; t < FRAME; t++) begin
      logic [3:0]  e_row;
      logic        e_en;
      logic [15:0] e_cols;
      logic        e_fs;
      e_row  = 4'(t / SLOT);
      e_en   = (t % SLOT) != 0;
      e_cols = e_en ? pat[t / SLOT] : 16'h0000;
      e_fs   = (t == 0);
      checks++;
      if (row !== e_row) begin
        failures++;
        $display("FAIL %s row t=%0d got=%0d exp=%0d", name, t, row, e_row);
      end
      checks++;
      if (row_en !== e_en) begin
        failures++;
        $display("FAIL %s row_en t=%0d got=%0b exp=%0b", name, t, row_en, e_en);
      end
      checks++;
      if (cols !== e_cols) begin
        failures++;
        $display("FAIL %s cols t=%0d got=%h exp=%h", name, t, cols, e_cols);
      end
      checks++;
      if (frame_start !== e_fs) begin
        failures++;
        $display("FAIL %s frame_start t=%0d got=%0b exp=%0b", name, t,
                 frame_start, e_fs);
      end
      if (t == chg_t) ball_y = chg_by;
      @(negedge clk);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    logic [15:0] pat [16];
    pat = '{default: 16'h0000};
    set_inputs(4'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (row !== 4'd0 || row_en !== 1'b0 || cols !== 16'h0000 ||
          frame_start !== 1'b0) begin
        failures++;
        $display("FAIL reset_held got row=%0d en=%0b cols=%h fs=%0b exp 0/0/0000/0",
                 row, row_en, cols, frame_start);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    // Paddles at row 0 cover rows 0..2. The ball at (0,0) lands on bit 0.
    pat[0] = 16'h8001;
    pat[1] = 16'h8001;
    pat[2] = 16'h8001;
    run_frame(pat, -1, 4'd0, "reset_frame");
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_t144 frame_start got=%0b exp=1", frame_start);
    end
  endtask

  task automatic test_ball_render();
    logic [15:0] pat [16];
    pat = '{default: 16'h0000};
    set_inputs(4'd5, 4'd3, 4'd8, 4'd8);
    do_reset();
    pat[3]  = 16'h0020;
    pat[8]  = 16'h8001;
    pat[9]  = 16'h8001;
    pat[10] = 16'h8001;
    run_frame(pat, -1, 4'd0, "ball_render");
  endtask

  task automatic test_clipping();
    logic [15:0] pat [16];
    pat = '{default: 16'h0000};
    set_inputs(4'd7, 4'd0, 4'd14, 4'd15);
    do_reset();
    pat[0]  = 16'h0080;
    pat[14] = 16'h0001;
    pat[15] = 16'h8001;
    run_frame(pat, -1, 4'd0, "clipping");
  endtask

  task automatic test_overlap();
    logic [15:0] pat [16];
    pat = '{default: 16'h0000};
    set_inputs(4'd0, 4'd9, 4'd8, 4'd0);
    do_reset();
    pat[0]  = 16'h8000;
    pat[1]  = 16'h8000;
    pat[2]  = 16'h8000;
    pat[8]  = 16'h0001;
    pat[9]  = 16'h0001;
    pat[10] = 16'h0001;
    run_frame(pat, -1, 4'd0, "overlap");
  endtask

  // ball_y changes mid-frame. The change shows only after the next
  // frame_start. The two frames also run back to back.
  task automatic test_back_to_back();
    logic [15:0] pat [16];
    pat = '{default: 16'h0000};
    set_inputs(4'd2, 4'd3, 4'd0, 4'd0);
    do_reset();
    pat[0] = 16'h8001;
    pat[1] = 16'h8001;
    pat[2] = 16'h8001;
    pat[3] = 16'h0004;
    run_frame(pat, 50, 4'd4, "tear_free_f1");
    pat[3] = 16'h0000;
    pat[4] = 16'h0004;
    run_frame(pat, -1, 4'd0, "tear_free_f2");
  endtask

  task automatic test_reset_mid_scan();
    logic [15:0] pat [16];
    pat = '{default: 16'h0000};
    set_inputs(4'd5, 4'd3, 4'd8, 4'd8);
    do_reset();
    for (int t = 0; t < 70; t++) @(negedge clk);
    checks++;
    if (row !== 4'd7 || row_en !== 1'b1 || cols !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_pre got row=%0d en=%0b cols=%h exp 7/1/0000",
               row, row_en, cols);
    end
    reset = 1'b0;
    set_inputs(4'd9, 4'd12, 4'd4, 4'd4);
    @(negedge clk);
    checks++;
    if (row !== 4'd0 || row_en !== 1'b0 || cols !== 16'h0000 ||
        frame_start !== 1'b0) begin
      failures++;
      $display("FAIL midreset_held got row=%0d en=%0b cols=%h fs=%0b exp 0/0/0000/0",
               row, row_en, cols, frame_start);
    end
    reset = 1'b1;
    @(negedge clk);
    pat[4]  = 16'h8001;
    pat[5]  = 16'h8001;
    pat[6]  = 16'h8001;
    pat[12] = 16'h0200;
    run_frame(pat, -1, 4'd0, "midreset_frame");
  endtask

  // Sequencer and final report
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    set_inputs(4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_ball_render();
    test_clipping();
    test_overlap();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
